// File: rtl/frame_seq_ctrl_if.sv
//============================================================================
// Module      : frame_seq_ctrl_if
// Description : Pixel stream bundle for the frame sequencer. Carries the
//               input gray-pixel stream (s_*) and the output edge-pixel
//               stream with row/frame markers (m_*).
//               Modports:
//                 master - stream endpoint outside the sequencer
//                          (drives s_valid/s_data/m_ready)
//                 slave  - the sequencer itself
//                          (drives s_ready/m_valid/m_data/m_eol/m_eof)
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface frame_seq_ctrl_if #(
    parameter int PIX_W = 8
) ();
    logic             s_valid;
    logic             s_ready;
    logic [PIX_W-1:0] s_data;
    logic             m_valid;
    logic             m_ready;
    logic [PIX_W-1:0] m_data;
    logic             m_eol;
    logic             m_eof;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_eol, m_eof
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_eol, m_eof
    );
endinterface

`default_nettype wire

// File: rtl/frame_seq_ctrl.sv
//============================================================================
// Module      : frame_seq_ctrl
// Description : Frame-level sequencer for the edge-detection core. Loads one
//               full frame into the core (dlay=1), primes the core pipeline,
//               then drains one full frame of edge pixels (dlay=0) onto a
//               registered valid/ready stream with eol/eof markers.
//               Back-pressure toward the core is applied through core_en.
// Ports       : clk, rst_n (async, active low)
//               start/busy/done   - frame control
//               sif (slave)       - s_* input stream, m_* output stream
//               dlay/core_en/core_din/core_dou - core phase, enable, data
//               stall_cnt         - stall/starvation cycle counter
// Option      : FRAME_SEQ_STALL_CNT_EN - when defined, stall_cnt counts LOAD
//               cycles without input and OUT cycles with output blocked
//               (saturating, cleared on accepted start); otherwise it is 0.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module frame_seq_ctrl #(
    parameter int IMG_W    = 800,
    parameter int IMG_H    = 600,
    parameter int PIX_W    = 8,
    parameter int PIPE_LAT = 2
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             start,
    output logic                  busy,
    output logic                  done,
    output logic                  dlay,
    output logic                  core_en,
    output logic [PIX_W-1:0]      core_din,
    input  wire logic [PIX_W-1:0] core_dou,
    output logic [31:0]           stall_cnt,
    frame_seq_ctrl_if.slave       sif
);

    localparam int c_COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int c_ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int c_PL_W  = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_W - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_H - 1);
    localparam logic [c_PL_W-1:0]  c_PL_LAST  = c_PL_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_PRIME = 3'd2,
        S_OUT   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [c_COL_W-1:0] r_col;
    logic [c_ROW_W-1:0] r_row;
    logic [c_PL_W-1:0]  r_pcnt;
    logic [PIX_W-1:0]   r_din;
    logic               r_m_valid;
    logic [PIX_W-1:0]   r_m_data;
    logic               r_m_eol;
    logic               r_m_eof;
    // Set once the last pixel of the frame has been pulled out of the core;
    // stops further core advancement while that pixel waits for its handshake.
    logic               r_all_taken;

    logic               w_s_ready;
    logic               w_in_hs;
    logic               w_last_pos;
    logic               w_out_take;
    logic               w_out_hs;

    assign w_in_hs    = (r_state == S_LOAD) && sif.s_valid;
    assign w_last_pos = (r_col == c_COL_LAST) && (r_row == c_ROW_LAST);
    // The output register may accept a new pixel when it is empty or is
    // being emptied this cycle; the core advances exactly then.
    assign w_out_take = (r_state == S_OUT) && !r_all_taken && (!r_m_valid || sif.m_ready);
    assign w_out_hs   = r_m_valid && sif.m_ready;

    //------------------------------------------------------------------------
    // State register
    //------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //------------------------------------------------------------------------
    // Next state and phase outputs
    //------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        dlay        = 1'b1;
        w_s_ready   = 1'b0;
        core_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                busy      = 1'b1;
                w_s_ready = 1'b1;
                core_en   = sif.s_valid;
                if (w_in_hs && w_last_pos) begin
                    w_state_nxt = (PIPE_LAT == 0) ? S_OUT : S_PRIME;
                end
            end
            S_PRIME: begin
                busy    = 1'b1;
                dlay    = 1'b0;
                core_en = 1'b1;
                if (r_pcnt == c_PL_LAST) begin
                    w_state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                busy    = 1'b1;
                dlay    = 1'b0;
                core_en = w_out_take;
                if (w_out_hs && r_m_eof) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                dlay        = 1'b0;
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    //------------------------------------------------------------------------
    // Position counters, core input hold and registered output stage
    //------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col       <= '0;
            r_row       <= '0;
            r_pcnt      <= '0;
            r_din       <= '0;
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
            r_m_eol     <= 1'b0;
            r_m_eof     <= 1'b0;
            r_all_taken <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_col       <= '0;
                        r_row       <= '0;
                        r_pcnt      <= '0;
                        r_all_taken <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (w_in_hs) begin
                        r_din <= sif.s_data;
                        if (w_last_pos) begin
                            r_col <= '0;
                            r_row <= '0;
                        end else if (r_col == c_COL_LAST) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                S_PRIME: begin
                    r_pcnt <= (r_pcnt == c_PL_LAST) ? '0 : r_pcnt + 1'b1;
                end
                S_OUT: begin
                    if (w_out_take) begin
                        r_m_valid <= 1'b1;
                        r_m_data  <= core_dou;
                        r_m_eol   <= (r_col == c_COL_LAST);
                        r_m_eof   <= w_last_pos;
                        if (w_last_pos) begin
                            r_col       <= '0;
                            r_row       <= '0;
                            r_all_taken <= 1'b1;
                        end else if (r_col == c_COL_LAST) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end else if (w_out_hs) begin
                        r_m_valid <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_m_valid   <= 1'b0;
                    r_m_eol     <= 1'b0;
                    r_m_eof     <= 1'b0;
                    r_all_taken <= 1'b0;
                end
                default: begin
                    r_m_valid <= 1'b0;
                end
            endcase
        end
    end

    // The accepted pixel reaches the core in its handshake cycle; the
    // register holds it afterwards so core_din stays stable between pixels.
    assign core_din    = w_in_hs ? sif.s_data : r_din;

    assign sif.s_ready = w_s_ready;
    assign sif.m_valid = r_m_valid;
    assign sif.m_data  = r_m_data;
    assign sif.m_eol   = r_m_eol;
    assign sif.m_eof   = r_m_eof;

    //------------------------------------------------------------------------
    // Stall / starvation counter
    //------------------------------------------------------------------------
`ifdef FRAME_SEQ_STALL_CNT_EN
    logic [31:0] r_stall;
    logic        w_stall_ev;

    assign w_stall_ev = ((r_state == S_LOAD) && !sif.s_valid) ||
                        ((r_state == S_OUT) && r_m_valid && !sif.m_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_stall <= '0;
        end else if (w_stall_ev && (r_stall != 32'hFFFF_FFFF)) begin
            r_stall <= r_stall + 32'd1;
        end
    end

    assign stall_cnt = r_stall;
`else
    assign stall_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_frame_seq_ctrl.sv
//============================================================================
// Module      : tb_frame_seq_ctrl
// Description : Self-checking bench for frame_seq_ctrl on an 8x4 frame with
//               a behavioural edge core (stores the frame during load, then
//               returns pixel ^ 8'h5A through a 2-stage enabled pipeline).
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_frame_seq_ctrl;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int PW = 8;
    localparam int PL = 2;
    localparam int N  = W * H;
    localparam int EN_EXP = N + PL + N;
`ifdef FRAME_SEQ_STALL_CNT_EN
    localparam int STALL_EXP = 12;
`else
    localparam int STALL_EXP = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, dlay, core_en;
    logic [PW-1:0] core_din;
    logic [PW-1:0] core_dou;
    logic [31:0]   stall_cnt;

    frame_seq_ctrl_if #(.PIX_W(PW)) sif ();

    frame_seq_ctrl #(
        .IMG_W(W), .IMG_H(H), .PIX_W(PW), .PIPE_LAT(PL)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .dlay(dlay), .core_en(core_en), .core_din(core_din),
        .core_dou(core_dou), .stall_cnt(stall_cnt), .sif(sif)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // Control flags from the main sequence
    logic model_clr = 1'b0;
    logic mon_clr   = 1'b0;
    int   low_pct   = 0;
    logic low_req   = 1'b0;

    //------------------------------------------------------------------------
    // Core model
    //------------------------------------------------------------------------
    logic [PW-1:0] mem [0:N-1];
    int            wr_i = 0;
    int            rd_i = 0;
    logic [PW-1:0] pipe0 = '0;
    logic [PW-1:0] pipe1 = '0;

    always @(posedge clk) begin
        if (model_clr) begin
            wr_i  <= 0;
            rd_i  <= 0;
            pipe0 <= '0;
            pipe1 <= '0;
        end else if (core_en) begin
            if (dlay) begin
                if (wr_i < N) mem[wr_i] <= core_din;
                wr_i <= wr_i + 1;
            end else begin
                pipe0 <= (rd_i < N) ? (mem[rd_i] ^ 8'h5A) : 8'h00;
                pipe1 <= pipe0;
                rd_i  <= rd_i + 1;
            end
        end
    end
    assign core_dou = pipe1;

    //------------------------------------------------------------------------
    // Output monitor (samples at falling edge)
    //------------------------------------------------------------------------
    logic [PW-1:0] obs_d [0:N-1];
    logic          obs_l [0:N-1];
    logic          obs_f [0:N-1];
    int            out_cnt = 0;
    int            en_cnt = 0;
    int            done_cnt = 0;
    int            stab_bad = 0;
    int            mon_low = 0;
    logic          prev_stall = 1'b0;
    logic [PW+1:0] prev_v = '0;

    always @(negedge clk) begin
        if (mon_clr) begin
            out_cnt    <= 0;
            en_cnt     <= 0;
            done_cnt   <= 0;
            stab_bad   <= 0;
            mon_low    <= 0;
            prev_stall <= 1'b0;
        end else if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (core_en) en_cnt <= en_cnt + 1;
            if (done) done_cnt <= done_cnt + 1;
            if (prev_stall && (!sif.m_valid || ({sif.m_data, sif.m_eol, sif.m_eof} != prev_v)))
                stab_bad <= stab_bad + 1;
            if (sif.m_valid && !sif.m_ready) mon_low <= mon_low + 1;
            prev_stall <= sif.m_valid && !sif.m_ready;
            prev_v     <= {sif.m_data, sif.m_eol, sif.m_eof};
            if (sif.m_valid && sif.m_ready) begin
                if (out_cnt < N) begin
                    obs_d[out_cnt] <= sif.m_data;
                    obs_l[out_cnt] <= sif.m_eol;
                    obs_f[out_cnt] <= sif.m_eof;
                end
                out_cnt <= out_cnt + 1;
            end
        end
    end

    //------------------------------------------------------------------------
    // Downstream sink: random ready, or a directed 7-cycle hold after 10 outputs
    //------------------------------------------------------------------------
    always begin
        if (low_req && out_cnt >= 10 && mon_low < 7)
            sif.m_ready = 1'b0;
        else
            sif.m_ready = ($urandom_range(0, 99) >= low_pct);
        @(posedge clk);
        #1;
    end

    //------------------------------------------------------------------------
    // Tasks
    //------------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clr_and_start();
        @(posedge clk); #1;
        model_clr = 1'b1;
        mon_clr   = 1'b1;
        @(posedge clk); #1;
        model_clr = 1'b0;
        mon_clr   = 1'b0;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    // mode 0: no gaps, 1: random 50% gaps, 2: one idle cycle before pixels 3,7,11,20,25
    task automatic feed(input int mode);
        for (int i = 0; i < N; i++) begin
            int   g;
            int   guard;
            logic hs;
            g = 0;
            if (mode == 1) g = $urandom_range(0, 1);
            if (mode == 2) g = (i == 3 || i == 7 || i == 11 || i == 20 || i == 25) ? 1 : 0;
            repeat (g) begin
                sif.s_valid = 1'b0;
                @(posedge clk); #1;
            end
            sif.s_valid = 1'b1;
            sif.s_data  = 8'(i);
            guard = 0;
            hs    = 1'b0;
            while (!hs && guard < 200) begin
                @(negedge clk);
                hs = sif.s_ready;
                @(posedge clk); #1;
                guard++;
            end
            if (!hs) begin
                chk("s_ready_timeout", 32'd0, 32'd1);
                break;
            end
        end
        sif.s_valid = 1'b0;
    endtask

    task automatic wait_done();
        int cyc;
        cyc = 0;
        while (done_cnt == 0 && cyc < 3000) begin
            @(posedge clk);
            cyc++;
        end
        chk("done_seen", 32'(done_cnt != 0), 32'd1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string tag);
        int d_bad;
        d_bad = 0;
        chk({tag, "_count"}, out_cnt, N);
        chk({tag, "_core_en"}, en_cnt, EN_EXP);
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_stable"}, stab_bad, 0);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_dlay_end"}, 32'(dlay), 32'd1);
        for (int i = 0; i < N; i++) begin
            logic [PW-1:0] e;
            e = 8'(i) ^ 8'h5A;
            if (obs_d[i] !== e || obs_l[i] !== ((i % W) == W - 1) || obs_f[i] !== (i == N - 1)) begin
                chk($sformatf("%s_pix%0d", tag, i), {obs_d[i], 6'd0, obs_l[i], obs_f[i]},
                    {e, 6'd0, 1'(((i % W) == W - 1)), 1'(i == N - 1)});
                d_bad++;
            end
        end
        chk({tag, "_pixels_bad"}, d_bad, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"},    32'(busy), 32'd0);
        chk({tag, "_done"},    32'(done), 32'd0);
        chk({tag, "_s_ready"}, 32'(sif.s_ready), 32'd0);
        chk({tag, "_m_valid"}, 32'(sif.m_valid), 32'd0);
        chk({tag, "_m_eol"},   32'(sif.m_eol), 32'd0);
        chk({tag, "_m_eof"},   32'(sif.m_eof), 32'd0);
        chk({tag, "_m_data"},  32'(sif.m_data), 32'd0);
        chk({tag, "_dlay"},    32'(dlay), 32'd1);
        chk({tag, "_core_en"}, 32'(core_en), 32'd0);
        chk({tag, "_core_din"}, 32'(core_din), 32'd0);
        chk({tag, "_stall"},   stall_cnt, 32'd0);
    endtask

    //------------------------------------------------------------------------
    // Main sequence
    //------------------------------------------------------------------------
    initial begin
        sif.s_valid = 1'b0;
        sif.s_data  = '0;

        // Reset values
        #12;
        check_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Clean frame, full throughput
        low_pct = 0;
        clr_and_start();
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_s_ready", 32'(sif.s_ready), 32'd1);
        chk("load_dlay", 32'(dlay), 32'd1);
        feed(0);
        wait_done();
        check_frame("clean");

        // Random input gaps and output back-pressure
        low_pct = 30;
        clr_and_start();
        feed(1);
        wait_done();
        check_frame("random");

        // Start pulses during LOAD and OUT are ignored
        low_pct = 0;
        clr_and_start();
        fork
            feed(0);
            begin
                repeat (10) @(posedge clk);
                #1 start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
                repeat (40) @(posedge clk);
                #1 start = 1'b1;
                chk("poke_in_out", 32'(dlay), 32'd0);
                @(posedge clk);
                #1 start = 1'b0;
            end
        join
        wait_done();
        check_frame("restart_ignored");

        // Reset during OUT at row 2 col 3, then a fresh frame
        low_pct = 0;
        clr_and_start();
        feed(0);
        begin
            int cyc;
            cyc = 0;
            while (out_cnt < 2 * W + 3 && cyc < 500) begin
                @(negedge clk);
                cyc++;
            end
            chk("reach_row2_col3", 32'(out_cnt >= 2 * W + 3), 32'd1);
        end
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        clr_and_start();
        feed(0);
        wait_done();
        check_frame("after_reset");

        // Stall counter: 5 idle input cycles + 7 blocked output cycles
        low_pct = 0;
        low_req = 1'b1;
        clr_and_start();
        feed(2);
        wait_done();
        check_frame("stall");
        chk("stall_cnt", stall_cnt, STALL_EXP);
        low_req = 1'b0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
